// File: rtl/cq_consumer_mgt.sv
// Per-CQ consumer-index table: doorbells advance the consumer index, and queries
// return free-entry count and full/error flags for a producer offset.
module cq_consumer_mgt #(
  parameter int CQ_NUM_LOG = 14,
  parameter int CQE_LENGTH = 32,
  parameter int IDX_WIDTH  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        db_req_valid,
  input  logic [63:0] db_req_head,
  output logic        db_req_ready,
  input  logic        qry_req_valid,
  input  logic [95:0] qry_req_head,
  output logic        qry_req_ready,
  output logic        qry_resp_valid,
  output logic [63:0] qry_resp_head,
  input  logic        qry_resp_ready
);

  // state       | meaning
  // ST_INIT     | clearing the table, one entry per cycle
  // ST_IDLE     | arbitrating doorbells and queries
  // ST_QRY_CALC | table read data valid, computing free space
  // ST_QRY_RESP | holding the response until it is consumed
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_QRY_CALC, ST_QRY_RESP} state_t;
  typedef enum logic {GR_DB, GR_QRY} grant_t;

  localparam int DEPTH   = 1 << CQ_NUM_LOG;
  localparam int CQE_LOG = $clog2(CQE_LENGTH);

  state_t                  state_q, state_d;
  grant_t                  last_grant_q, last_grant_d;
  logic [CQ_NUM_LOG-1:0]   init_cnt_q, init_cnt_d;
  logic [23:0]             cqn_q, cqn_d;
  logic [IDX_WIDTH-1:0]    e_q, e_d;
  logic [IDX_WIDTH-1:0]    pi_q, pi_d;
  logic [IDX_WIDTH-1:0]    free_q, free_d;
  logic                    full_q, full_d;
  logic                    err_q, err_d;

  logic                    wea;
  logic [CQ_NUM_LOG-1:0]   addra;
  logic [IDX_WIDTH-1:0]    dina;
  logic                    enb;
  logic [CQ_NUM_LOG-1:0]   addrb;
  logic [IDX_WIDTH-1:0]    doutb_q;
  logic [IDX_WIDTH-1:0]    mem [DEPTH];

  logic                    grant_db, grant_qry;
  logic [IDX_WIDTH-1:0]    ci, used, calc_free;
  logic                    unused_ok;

  assign unused_ok = ^{db_req_head, qry_req_head};

  // Simple dual-port table, one-cycle read latency, no reset (INIT clears it).
  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) doutb_q <= mem[addrb];
  end

  always_comb begin
    grant_db  = 1'b0;
    grant_qry = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_db  = db_req_valid  && (!qry_req_valid || last_grant_q == GR_QRY);
      grant_qry = qry_req_valid && (!db_req_valid  || last_grant_q == GR_DB);
    end
  end

  always_comb begin
    ci   = doutb_q;
    used = (pi_q >= ci) ? (pi_q - ci) : (pi_q + e_q - ci);
    calc_free = e_q - IDX_WIDTH'(1) - used;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    init_cnt_d    = init_cnt_q;
    cqn_d         = cqn_q;
    e_d           = e_q;
    pi_d          = pi_q;
    free_d        = free_q;
    full_d        = full_q;
    err_d         = err_q;
    wea           = 1'b0;
    addra         = db_req_head[CQ_NUM_LOG-1:0];
    dina          = db_req_head[32 +: IDX_WIDTH];
    enb           = 1'b0;
    addrb         = qry_req_head[CQ_NUM_LOG-1:0];
    db_req_ready  = 1'b0;
    qry_req_ready = 1'b0;

    case (state_q)
      ST_INIT: begin
        wea        = 1'b1;
        addra      = init_cnt_q;
        dina       = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {CQ_NUM_LOG{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (grant_db) begin
          db_req_ready = 1'b1;
          wea          = 1'b1;
          last_grant_d = GR_DB;
        end else if (grant_qry) begin
          qry_req_ready = 1'b1;
          enb           = 1'b1;
          last_grant_d  = GR_QRY;
          cqn_d         = qry_req_head[23:0];
          // Upper cq_length bits beyond the index range are deliberately dropped.
          e_d           = qry_req_head[32+CQE_LOG +: IDX_WIDTH];
          pi_d          = IDX_WIDTH'(qry_req_head[64+CQE_LOG +: IDX_WIDTH-CQE_LOG]);
          state_d       = ST_QRY_CALC;
        end
      end
      ST_QRY_CALC: begin
        if (ci >= e_q || pi_q >= e_q) begin
          err_d  = 1'b1;
          full_d = 1'b1;
          free_d = '0;
        end else begin
          err_d  = 1'b0;
          free_d = calc_free;
          full_d = (calc_free == '0);
        end
        state_d = ST_QRY_RESP;
      end
      ST_QRY_RESP: begin
        if (qry_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      last_grant_q <= GR_QRY;
      init_cnt_q   <= '0;
      cqn_q        <= '0;
      e_q          <= '0;
      pi_q         <= '0;
      free_q       <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      init_cnt_q   <= init_cnt_d;
      cqn_q        <= cqn_d;
      e_q          <= e_d;
      pi_q         <= pi_d;
      free_q       <= free_d;
      full_q       <= full_d;
      err_q        <= err_d;
    end
  end

  assign qry_resp_valid = (state_q == ST_QRY_RESP);
  assign qry_resp_head  = {14'h0, err_q, full_q, 24'(free_q), cqn_q};

endmodule

// File: tb/tb_cq_consumer_mgt.sv
// Directed bench for cq_consumer_mgt with a 16-entry table.
module tb_cq_consumer_mgt;

  logic        clk = 1'b0;
  logic        rst;
  logic        db_req_valid;
  logic [63:0] db_req_head;
  logic        db_req_ready;
  logic        qry_req_valid;
  logic [95:0] qry_req_head;
  logic        qry_req_ready;
  logic        qry_resp_valid;
  logic [63:0] qry_resp_head;
  logic        qry_resp_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cq_consumer_mgt #(.CQ_NUM_LOG(4), .CQE_LENGTH(32), .IDX_WIDTH(24)) dut (
    .clk(clk), .rst(rst),
    .db_req_valid(db_req_valid), .db_req_head(db_req_head), .db_req_ready(db_req_ready),
    .qry_req_valid(qry_req_valid), .qry_req_head(qry_req_head), .qry_req_ready(qry_req_ready),
    .qry_resp_valid(qry_resp_valid), .qry_resp_head(qry_resp_head), .qry_resp_ready(qry_resp_ready)
  );

  function automatic logic [63:0] db_hd(input logic [23:0] cqn, input logic [23:0] ci);
    return {8'h0, ci, 8'h0, cqn};
  endfunction

  function automatic logic [95:0] q_hd(input logic [23:0] cqn, input logic [31:0] len, input logic [23:0] off);
    return {8'h0, off, len, 8'h0, cqn};
  endfunction

  task automatic do_db(input logic [23:0] cqn, input logic [23:0] ci);
    int n = 0;
    @(negedge clk);
    db_req_head = db_hd(cqn, ci);
    db_req_valid = 1'b1;
    #1;
    while (!db_req_ready && n < 100) begin @(negedge clk); #1; n++; end
    total++;
    if (db_req_ready !== 1'b1) begin bad++; $display("FAIL db_accept ready=%b required=1", db_req_ready); end
    @(posedge clk); #1 db_req_valid = 1'b0;
  endtask

  task automatic qry_accept(input logic [23:0] cqn, input logic [31:0] len, input logic [23:0] off,
                            output int waits);
    waits = 0;
    @(negedge clk);
    qry_req_head = q_hd(cqn, len, off);
    qry_req_valid = 1'b1;
    #1;
    while (!qry_req_ready && waits < 100) begin @(negedge clk); #1; waits++; end
    total++;
    if (qry_req_ready !== 1'b1) begin bad++; $display("FAIL qry_accept ready=%b required=1", qry_req_ready); end
    @(posedge clk); #1 qry_req_valid = 1'b0;
  endtask

  task automatic check_resp(input string nm, input logic [23:0] cqn, input logic [23:0] free,
                            input logic full, input logic err);
    logic [63:0] exp;
    exp = {14'h0, err, full, free, cqn};
    @(negedge clk);
    total++;
    if (qry_resp_valid !== 1'b0) begin bad++; $display("FAIL %s_early valid=%b required=0", nm, qry_resp_valid); end
    @(negedge clk);
    total++;
    if (qry_resp_valid !== 1'b1) begin bad++; $display("FAIL %s_valid valid=%b required=1", nm, qry_resp_valid); end
    total++;
    if (qry_resp_head !== exp) begin bad++; $display("FAIL %s_head got=%h required=%h", nm, qry_resp_head, exp); end
    if (qry_resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    int w;
    @(negedge clk);
    db_req_head = db_hd(24'd3, 24'd0);
    qry_req_head = q_hd(24'd3, 32'd256, 24'd0);
    db_req_valid = 1'b1;
    qry_req_valid = 1'b1;
    #1;
    total++;
    if ({qry_resp_valid, db_req_ready, qry_req_ready} !== 3'b000 || qry_resp_head !== 64'h0) begin
      bad++; $display("FAIL rst_outputs v=%b dr=%b qr=%b head=%h required all 0",
                      qry_resp_valid, db_req_ready, qry_req_ready, qry_resp_head);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (db_req_ready !== 1'b0 || qry_req_ready !== 1'b0) begin
        bad++; $display("FAIL init_ready cycle=%0d dr=%b qr=%b required 0", i, db_req_ready, qry_req_ready);
      end
    end
    db_req_valid = 1'b0;
    qry_req_valid = 1'b0;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    total++;
    if (w != 0) begin bad++; $display("FAIL init_len waits=%0d required=0", w); end
    check_resp("empty", 24'd3, 24'd7, 1'b0, 1'b0);
  endtask

  task automatic test_ring;
    int w;
    do_db(24'd3, 24'd5);
    qry_accept(24'd3, 32'd256, 24'd96, w);
    check_resp("pi_lt_ci", 24'd3, 24'd1, 1'b0, 1'b0);
    do_db(24'd3, 24'd2);
    qry_accept(24'd3, 32'd256, 24'd32, w);
    check_resp("full", 24'd3, 24'd0, 1'b1, 1'b0);
    do_db(24'd3, 24'd1);
    qry_accept(24'd3, 32'd256, 24'd32, w);
    check_resp("pi_eq_ci", 24'd3, 24'd7, 1'b0, 1'b0);
  endtask

  task automatic test_arbitration;
    int w;
    int n;
    // last grant was a query: the doorbell wins
    @(negedge clk);
    db_req_head = db_hd(24'd3, 24'd4);
    qry_req_head = q_hd(24'd3, 32'd256, 24'd0);
    db_req_valid = 1'b1;
    qry_req_valid = 1'b1;
    #1;
    total++;
    if (db_req_ready !== 1'b1 || qry_req_ready !== 1'b0) begin
      bad++; $display("FAIL arb_db_first dr=%b qr=%b required dr=1 qr=0", db_req_ready, qry_req_ready);
    end
    @(posedge clk); #1 db_req_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (qry_req_ready !== 1'b1) begin bad++; $display("FAIL arb_qry_second qr=%b required=1", qry_req_ready); end
    @(posedge clk); #1 qry_req_valid = 1'b0;
    check_resp("arb_new_ci", 24'd3, 24'd3, 1'b0, 1'b0);
    // last grant was a doorbell: the query wins and sees the old index
    do_db(24'd3, 24'd4);
    @(negedge clk);
    db_req_head = db_hd(24'd3, 24'd6);
    qry_req_head = q_hd(24'd3, 32'd256, 24'd0);
    db_req_valid = 1'b1;
    qry_req_valid = 1'b1;
    #1;
    total++;
    if (db_req_ready !== 1'b0 || qry_req_ready !== 1'b1) begin
      bad++; $display("FAIL arb_qry_first dr=%b qr=%b required dr=0 qr=1", db_req_ready, qry_req_ready);
    end
    @(posedge clk); #1 qry_req_valid = 1'b0;
    check_resp("arb_old_ci", 24'd3, 24'd3, 1'b0, 1'b0);
    n = 0;
    @(negedge clk); #1;
    while (!db_req_ready && n < 100) begin @(negedge clk); #1; n++; end
    total++;
    if (db_req_ready !== 1'b1) begin bad++; $display("FAIL arb_db_waited ready=%b required=1", db_req_ready); end
    @(posedge clk); #1 db_req_valid = 1'b0;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    check_resp("db_not_dropped", 24'd3, 24'd5, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    int w;
    logic [63:0] exp;
    exp = {14'h0, 1'b0, 1'b0, 24'd5, 24'd3};
    qry_resp_ready = 1'b0;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    db_req_head = db_hd(24'd3, 24'd7);
    db_req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (qry_resp_valid !== 1'b1 || qry_resp_head !== exp || db_req_ready !== 1'b0) begin
        bad++; $display("FAIL hold cycle=%0d v=%b head=%h dr=%b required v=1 head=%h dr=0",
                        i, qry_resp_valid, qry_resp_head, db_req_ready, exp);
      end
    end
    qry_resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (qry_resp_valid !== 1'b0) begin bad++; $display("FAIL hold_release valid=%b required=0", qry_resp_valid); end
    @(negedge clk); #1;
    total++;
    if (db_req_ready !== 1'b1) begin bad++; $display("FAIL db_after_resp ready=%b required=1", db_req_ready); end
    @(posedge clk); #1 db_req_valid = 1'b0;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    check_resp("ci7", 24'd3, 24'd6, 1'b0, 1'b0);
  endtask

  task automatic test_err_reset;
    int w;
    do_db(24'd3, 24'd9);
    qry_resp_ready = 1'b0;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    check_resp("ci_err", 24'd3, 24'd0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    total++;
    if (qry_resp_valid !== 1'b0 || qry_resp_head !== 64'h0 || db_req_ready !== 1'b0 || qry_req_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid v=%b head=%h dr=%b qr=%b required all 0",
                      qry_resp_valid, qry_resp_head, db_req_ready, qry_req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    qry_resp_ready = 1'b1;
    qry_accept(24'd3, 32'd256, 24'd0, w);
    total++;
    if (w != 15) begin bad++; $display("FAIL reinit_len waits=%0d required=15", w); end
    check_resp("reinit_ci0", 24'd3, 24'd7, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries;
    int w;
    qry_accept(24'd3, 32'd256, 24'd256, w);
    check_resp("pi_err", 24'd3, 24'd0, 1'b1, 1'b1);
    qry_accept(24'd3, 32'h2000_0100, 24'd0, w);
    check_resp("len_trunc", 24'd3, 24'd7, 1'b0, 1'b0);
    do_db(24'h13, 24'd2);
    qry_accept(24'd3, 32'd256, 24'd0, w);
    check_resp("cqn_trunc", 24'd3, 24'd1, 1'b0, 1'b0);
    qry_accept(24'd5, 32'd512, 24'd480, w);
    check_resp("len512", 24'd5, 24'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    db_req_valid = 1'b0;
    db_req_head = '0;
    qry_req_valid = 1'b0;
    qry_req_head = '0;
    qry_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_ring();
    test_arbitration();
    test_backpressure();
    test_err_reset();
    test_boundaries();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
